// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among NREQ requesters.
// Captures the winner's operand, issues start, waits for done (with watchdog) and acks the owner.
module bcd_conv_arbiter #(
  parameter int NREQ    = 2,
  parameter int BIN_W   = 13,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BIN_W-1:0] bin_in,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [15:0]           bcd_out,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic                  conv_start,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic                  conv_ready,
  input  logic                  conv_done_tick,
  input  logic [15:0]           conv_bcd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  localparam int TW = $clog2(TIMEOUT);
  // Abort when the timer would reach TIMEOUT-1: ack lands TIMEOUT cycles after start.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

  state_t            state_r, state_s;
  logic [1:0]        last_r, owner_r, grant_idx_s;
  logic [BIN_W-1:0]  conv_bin_r, grant_bin_s;
  logic [15:0]       bcd_out_r;
  logic [TW-1:0]     timer_r;
  logic [NREQ-1:0]   ack_r, ack_s;
  logic              err_r, err_s, busy_r, busy_s, start_r, start_s;
  logic              grant_found_s, timeout_s;
  logic [3:0]        req_ext_s;
  logic [2:0]        cand_s;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    req_ext_s     = 4'(req);
    grant_found_s = 1'b0;
    grant_idx_s   = 2'd0;
    cand_s        = 3'd0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = 3'(last_r) + 3'(i);
      if (cand_s >= 3'(NREQ)) cand_s = cand_s - 3'(NREQ);
      else                    cand_s = cand_s;
      if (!grant_found_s && req_ext_s[cand_s[1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    grant_bin_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx_s == 2'(k)) grant_bin_s = bin_in[k*BIN_W +: BIN_W];
      else                      grant_bin_s = grant_bin_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    timeout_s = (timer_r == TLAST);
    state_s   = state_r;
    case (state_r)
      IDLE:    if (conv_ready && grant_found_s) state_s = ISSUE;
               else                              state_s = IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    if (conv_done_tick || timeout_s) state_s = DELIVER;
               else                              state_s = WAIT;
      DELIVER: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; done wins over a coincident timeout.
  always_comb begin
    ack_s   = '0;
    busy_s  = (state_s != IDLE);
    start_s = (state_s == ISSUE);
    err_s   = (state_s == DELIVER) && !conv_done_tick;
    for (int k = 0; k < NREQ; k++) begin
      if ((state_s == DELIVER) && (owner_r == 2'(k))) ack_s[k] = 1'b1;
      else                                            ack_s[k] = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      start_r <= 1'b0;
    end else begin
      ack_r   <= ack_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      start_r <= start_s;
    end
  end

  // Datapath: grant capture, watchdog timer, result capture and pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r     <= 2'(NREQ - 1);
      owner_r    <= 2'd0;
      conv_bin_r <= '0;
      bcd_out_r  <= 16'h0000;
      timer_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (conv_ready && grant_found_s) begin
            owner_r    <= grant_idx_s;
            conv_bin_r <= grant_bin_s;
          end
        end
        ISSUE:   timer_r <= '0;
        WAIT: begin
          if (conv_done_tick) bcd_out_r <= conv_bcd;
          else                timer_r   <= timer_r + TW'(1);
        end
        DELIVER: last_r <= owner_r;
        default: timer_r <= '0;
      endcase
    end
  end

  assign ack        = ack_r;
  assign err        = err_r;
  assign busy       = busy_r;
  assign conv_start = start_r;
  assign owner      = owner_r;
  assign conv_bin   = conv_bin_r;
  assign bcd_out    = bcd_out_r;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter (NREQ=2, BIN_W=13, TIMEOUT=64).
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [25:0] bin_in = 26'd0;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] bcd_out;
  logic [1:0]  owner;
  logic        busy;
  logic        conv_start;
  logic [12:0] conv_bin;
  logic        conv_ready = 1'b1;
  logic        conv_done_tick = 1'b0;
  logic [15:0] conv_bcd = 16'h0000;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  bcd_conv_arbiter #(.NREQ(2), .BIN_W(13), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .bin_in(bin_in), .ack(ack), .err(err),
    .bcd_out(bcd_out), .owner(owner), .busy(busy), .conv_start(conv_start),
    .conv_bin(conv_bin), .conv_ready(conv_ready), .conv_done_tick(conv_done_tick),
    .conv_bcd(conv_bcd)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for conv_start; returns negedges waited, or -1 on expiry.
  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  // Converter model: done pulse n cycles after the start cycle; returns at the ack cycle.
  task automatic pulse_done(input int n, input logic [15:0] bcd);
    repeat (n) @(negedge clk);
    conv_bcd       = bcd;
    conv_done_tick = 1'b1;
    @(negedge clk);
    conv_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({ack, err, conv_start, busy} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {ack, err, conv_start, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({bcd_out, conv_bin, owner} !== 31'd0) $display("FAIL reset_data: got %h expected 0", {bcd_out, conv_bin, owner});
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c;
    req = 2'b01;
    bin_in[12:0] = 13'd1234;
    wait_start(c);
    chk_cnt++;
    if (c !== 1) $display("FAIL single_latency: got %0d expected 1", c);
    else pass_cnt++;
    chk_cnt++;
    if (conv_bin !== 13'd1234 || owner !== 2'd0 || busy !== 1'b1) $display("FAIL single_grant: got bin=%0d owner=%0d busy=%b expected 1234 0 1", conv_bin, owner, busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (conv_start !== 1'b0) $display("FAIL single_start_width: got %b expected 0", conv_start);
    else pass_cnt++;
    pulse_done(13, 16'h1234);
    req = 2'b00;
    chk_cnt++;
    if (ack !== 2'b01 || err !== 1'b0 || bcd_out !== 16'h1234) $display("FAIL single_ack: got ack=%b err=%b bcd=%h expected 01 0 1234", ack, err, bcd_out);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (ack !== 2'b00 || busy !== 1'b0) $display("FAIL single_after: got ack=%b busy=%b expected 00 0", ack, busy);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int c;
    logic [1:0]  exp_own [3];
    logic [15:0] exp_bcd [3];
    exp_own = '{2'd0, 2'd1, 2'd0};
    exp_bcd = '{16'h0042, 16'h8191, 16'h0042};
    do_reset();
    bin_in = {13'd8191, 13'd42};
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_start(c);
      chk_cnt++;
      if (owner !== exp_own[i]) $display("FAIL rr_owner%0d: got %0d expected %0d", i, owner, exp_own[i]);
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (c !== 2) $display("FAIL rr_gap%0d: got %0d expected 2", i, c);
        else pass_cnt++;
      end
      pulse_done(1, exp_bcd[i]);
      if (i == 2) req = 2'b00;
      chk_cnt++;
      if (ack !== (2'b01 << exp_own[i]) || bcd_out !== exp_bcd[i]) $display("FAIL rr_ack%0d: got ack=%b bcd=%h expected %b %h", i, ack, bcd_out, 2'b01 << exp_own[i], exp_bcd[i]);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int c;
    int n;
    req = 2'b01;
    bin_in[12:0] = 13'd77;
    wait_start(c);
    n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (ack !== 2'b00) begin
        n = k;
        break;
      end
    end
    req = 2'b00;
    chk_cnt++;
    if (n !== 64) $display("FAIL timeout_latency: got %0d expected 64", n);
    else pass_cnt++;
    chk_cnt++;
    if (ack !== 2'b01 || err !== 1'b1 || bcd_out !== 16'h0042) $display("FAIL timeout_ack: got ack=%b err=%b bcd=%h expected 01 1 0042", ack, err, bcd_out);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL timeout_err_width: got %b expected 0", err);
    else pass_cnt++;
    // Done on the last watchdog cycle must win.
    req = 2'b01;
    bin_in[12:0] = 13'd5;
    wait_start(c);
    pulse_done(63, 16'h0005);
    req = 2'b00;
    chk_cnt++;
    if (ack !== 2'b01 || err !== 1'b0 || bcd_out !== 16'h0005) $display("FAIL timeout_done_wins: got ack=%b err=%b bcd=%h expected 01 0 0005", ack, err, bcd_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_not_ready();
    logic seen;
    conv_ready = 1'b0;
    req = 2'b10;
    bin_in[25:13] = 13'd9;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (conv_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk_cnt++;
    if (seen !== 1'b0) $display("FAIL notready_hold: got activity=%b expected 0", seen);
    else pass_cnt++;
    conv_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (conv_start !== 1'b1 || owner !== 2'd1 || conv_bin !== 13'd9) $display("FAIL notready_grant: got start=%b owner=%0d bin=%0d expected 1 1 9", conv_start, owner, conv_bin);
    else pass_cnt++;
    pulse_done(2, 16'h0009);
    req = 2'b00;
    chk_cnt++;
    if (ack !== 2'b10) $display("FAIL notready_ack: got %b expected 10", ack);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int c;
    req = 2'b01;
    bin_in[12:0] = 13'd100;
    wait_start(c);
    bin_in[12:0] = 13'd200;
    repeat (3) @(negedge clk);
    req = 2'b00;
    chk_cnt++;
    if (conv_bin !== 13'd100) $display("FAIL opchg_bin: got %0d expected 100", conv_bin);
    else pass_cnt++;
    pulse_done(7, 16'h0100);
    chk_cnt++;
    if (ack !== 2'b01 || bcd_out !== 16'h0100) $display("FAIL opchg_ack: got ack=%b bcd=%h expected 01 0100", ack, bcd_out);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    logic seen;
    req = 2'b01;
    bin_in[12:0] = 13'd321;
    wait_start(c);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ack, err, conv_start, busy} !== 5'b0 || {bcd_out, conv_bin, owner} !== 31'd0) $display("FAIL midreset_values: got ctrl=%b data=%h expected 0 0", {ack, err, conv_start, busy}, {bcd_out, conv_bin, owner});
    else pass_cnt++;
    req = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    conv_bcd = 16'h0321;
    conv_done_tick = 1'b1;
    @(negedge clk);
    conv_done_tick = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (ack !== 2'b00 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen !== 1'b0 || bcd_out !== 16'h0000) $display("FAIL midreset_stray_done: got activity=%b bcd=%h expected 0 0000", seen, bcd_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_timeout();
    test_not_ready();
    test_operand_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
